// File: rtl/frac_sat_accum.sv
// frac_sat_accum: streaming signed fixed-point group accumulator with per-beat saturate/wrap
// and sticky overflow, valid/ready on both sides.
module frac_sat_accum #(
  parameter int WIDTH = 14,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sat_en,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_acc, w_base, w_sum;
  logic [WIDTH:0]   w_raw;
  logic [CNT_W-1:0] r_cnt, w_cnt_base, w_cnt;
  logic             r_sticky, w_ovf, w_sticky, w_accept, w_consume;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = flush ? IDLE : w_accept ? (in_last ? IDLE : ACCUM) : r_state;
  end

  always_comb begin
    busy     = (r_state == ACCUM);
    in_ready = ~flush & (~out_valid | out_ready);
  end

  // Overflow only possible when operands share a sign; the sum's sign then tells.
  always_comb begin
    w_accept   = in_valid & in_ready;
    w_consume  = out_valid & out_ready;
    w_base     = busy ? r_acc : '0;
    w_raw      = {w_base[WIDTH-1], w_base} + {in_data[WIDTH-1], in_data};
    w_ovf      = (w_base[WIDTH-1] == in_data[WIDTH-1]) & (w_raw[WIDTH-1] != w_base[WIDTH-1]);
    w_sum      = (w_ovf & in_sat_en) ? (w_base[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                       : {1'b0, {(WIDTH-1){1'b1}}})
                                     : w_raw[WIDTH-1:0];
    w_cnt_base = busy ? r_cnt : '0;
    w_cnt      = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
    w_sticky   = (busy & r_sticky) | w_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (flush | (w_accept & in_last)) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else if (w_accept) begin
        r_acc    <= w_sum;
        r_cnt    <= w_cnt;
        r_sticky <= w_sticky;
      end
      if (w_accept & in_last) begin
        out_data  <= w_sum;
        out_ovf   <= w_sticky;
        out_count <= w_cnt;
        out_valid <= 1'b1;
      end else if (w_consume) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_frac_sat_accum.sv
// tb_frac_sat_accum: scoreboard bench for frac_sat_accum (WIDTH=14, CNT_W=8 and a CNT_W=2 copy).
module tb_frac_sat_accum;
  logic        clk = 0, rst = 1;
  logic [13:0] in_data = 0, out_data;
  logic        in_valid = 0, in_last = 0, in_sat_en = 0, in_ready, flush = 0;
  logic        out_ovf, out_valid, out_ready = 1, busy;
  logic [7:0]  out_count;
  logic [13:0] d2 = 0, out_data2;
  logic        v2 = 0, l2 = 0, in_ready2, out_ovf2, out_valid2, busy2;
  logic [1:0]  out_count2;

  typedef struct packed {logic [13:0] d; logic o; logic [7:0] c;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int m_acc = 0, m_cnt = 0;
  bit m_stk = 0, m_busy = 0;

  frac_sat_accum #(.WIDTH(14), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_sat_en(in_sat_en), .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_ovf(out_ovf), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy));

  frac_sat_accum #(.WIDTH(14), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_last(l2),
    .in_sat_en(1'b1), .in_ready(in_ready2), .flush(1'b0), .out_data(out_data2),
    .out_ovf(out_ovf2), .out_count(out_count2), .out_valid(out_valid2), .out_ready(1'b1),
    .busy(busy2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got %0d/%0d/%0d, required no result", out_data, out_ovf, out_count);
      end else begin
        e = q.pop_front();
        if ({out_data, out_ovf, out_count} !== {e.d, e.o, e.c}) begin
          failures++;
          $display("FAIL sb_result: got %h/%0d/%0d, required %h/%0d/%0d",
                   out_data, out_ovf, out_count, e.d, e.o, e.c);
        end
      end
    end
  end

  task automatic model_clear();
    m_acc = 0; m_cnt = 0; m_stk = 0; m_busy = 0;
  endtask

  task automatic model_step(input int d, input bit last, input bit sat);
    int s, c;
    bit o, k;
    s = (m_busy ? m_acc : 0) + d;
    o = (s > 8191) || (s < -8192);
    if (o) s = sat ? (s > 0 ? 8191 : -8192) : (s > 8191 ? s - 16384 : s + 16384);
    k = (m_busy && m_stk) || o;
    c = (m_busy ? m_cnt : 0) + 1;
    if (c > 255) c = 255;
    if (last) begin
      q.push_back('{d: s[13:0], o: k, c: c[7:0]});
      model_clear();
    end else begin
      m_acc = s; m_cnt = c; m_stk = k; m_busy = 1;
    end
  endtask

  task automatic beat(input int d, input bit last, input bit sat);
    int n = 0;
    in_data = 14'(d); in_valid = 1; in_last = last; in_sat_en = sat;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL beat_timeout: in_ready=%0d, required 1 within 20 cycles", in_ready);
    end else model_step(d, last, sat);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_ovf, out_count, busy, in_ready} !== {1'b0, 14'd0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: got v=%0d d=%0d o=%0d c=%0d busy=%0d rdy=%0d, required 0/0/0/0/0/1",
               out_valid, out_data, out_ovf, out_count, busy, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    beat(100, 0, 1);
    beat(200, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %0d, required 0", out_valid); end
    beat(-50, 1, 1);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_ovf, out_count} !== {1'b1, 14'd250, 1'b0, 8'd3}) begin
      failures++;
      $display("FAIL basic_sum: got v=%0d %0d/%0d/%0d, required 1 250/0/3", out_valid, out_data, out_ovf, out_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    beat(8000, 0, 1); beat(500, 1, 1);
    @(negedge clk);
    checks++;
    if ({out_data, out_ovf} !== {14'h1FFF, 1'b1}) begin
      failures++; $display("FAIL ovf_sat_pos: got %h/%0d, required 1fff/1", out_data, out_ovf);
    end
    @(posedge clk); #1;
    beat(8000, 0, 0); beat(500, 1, 0);
    @(negedge clk);
    checks++;
    if ({out_data, out_ovf} !== {14'h2134, 1'b1}) begin
      failures++; $display("FAIL ovf_wrap: got %h/%0d, required 2134/1", out_data, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sticky();
    beat(-8000, 0, 1); beat(-500, 0, 1);
    checks++;
    if (dut.r_acc !== 14'h2000) begin failures++; $display("FAIL sticky_mid_acc: got %h, required 2000", dut.r_acc); end
    beat(300, 1, 1);
    @(negedge clk);
    checks++;
    if ({out_data, out_ovf, out_count} !== {14'(-7892), 1'b1, 8'd3}) begin
      failures++; $display("FAIL sticky_result: got %h/%0d/%0d, required %h/1/3", out_data, out_ovf, out_count, 14'(-7892));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    beat(5, 1, 1);
    in_data = 7; in_valid = 1; in_last = 1; in_sat_en = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_data, out_ovf, out_count} !== {1'b0, 1'b1, 14'd5, 1'b0, 8'd1}) begin
        failures++;
        $display("FAIL bp_hold: got rdy=%0d v=%0d %0d/%0d/%0d, required 0 1 5/0/1", in_ready, out_valid, out_data, out_ovf, out_count);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    beat(7, 1, 1);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data} !== {1'b1, 14'd7}) begin
      failures++; $display("FAIL bp_reload: got v=%0d d=%0d, required 1 7", out_valid, out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) beat(i * 3 - 8, 1, i[0]);
    @(negedge clk);
    chk("b2b_last_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    beat(10, 0, 1); beat(20, 0, 1);
    in_data = 99; in_valid = 1; in_last = 1; flush = 1;
    @(negedge clk);
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    model_clear();
    @(posedge clk); #1;
    flush = 0; in_valid = 0; in_last = 0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    beat(3, 1, 1);
    @(negedge clk);
    chk("flush_next", {out_data, out_count}, {14'd3, 8'd1});
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    beat(4, 0, 1);
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1; @(posedge clk); #1 rst = 0;
    model_clear();
    @(negedge clk);
    chk("rst_mid_after", {busy, out_valid, out_data, out_ovf, out_count}, 0);
    @(posedge clk); #1;
    out_ready = 0;
    beat(6, 1, 1);
    chk("rst_pend_before", {31'd0, out_valid}, 32'd1);
    rst = 1; @(posedge clk); #1 rst = 0;
    q.delete();
    @(negedge clk);
    chk("rst_pend_after", {busy, out_valid, out_data, out_ovf, out_count}, 0);
    @(posedge clk); #1;
    out_ready = 1;
  endtask

  task automatic test_count_sat();
    v2 = 1; d2 = 1; l2 = 0;
    for (int i = 0; i < 6; i++) begin
      l2 = (i == 5);
      @(negedge clk);
      chk("cnt_sat_ready", {31'd0, in_ready2}, 32'd1);
      @(posedge clk); #1;
    end
    v2 = 0; l2 = 0;
    @(negedge clk);
    chk("cnt_sat_result", {out_valid2, out_data2, out_ovf2, out_count2}, {1'b1, 14'd6, 1'b0, 2'd3});
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int g = 0; g < 6; g++) begin
      int len = $urandom_range(1, 5);
      bit sat = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) beat(int'($urandom_range(0, 16383)) - 8192, b == len - 1, sat);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_sticky();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_count_sat();
    test_random();
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frac_sat_accum.md
Name: frac_sat_accum

Overview:
Streaming signed fixed-point accumulator with saturation for the tensor-core datapath. It reduces a group of fraction operands, delimited by in_last, to one sum per group. Width and count range are parametrised, and saturate or wrap mode is selected per beat. Overflow is sticky across the group and reported with the result. Valid/ready handshakes are used on both sides, so it sits between the multiplier array and the result writeback.

Parameters:
WIDTH, 14, operand/result width, two's complement; MSB is the sign.
CNT_W, 8, width of the per-group beat counter.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
in_data  input  WIDTH  signed operand.
in_valid  input  1  operand valid.
in_last  input  1  operand is the final beat of the group.
in_sat_en  input  1  1 = saturate on overflow, 0 = wrap; sampled per accepted beat.
in_ready  output  1  block can accept a beat.
flush  input  1  abort the partial group.
out_data  output  WIDTH  group sum.
out_ovf  output  1  at least one overflow occurred in the group.
out_count  output  CNT_W  beats in the group, saturating.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
busy  output  1  a partial group is in progress (state ACCUM).

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE; acc, cnt and sticky ovf are cleared.
  - out_valid, out_data, out_ovf and out_count are all 0.
  - rst overrides every other input, including mid-group and with a result pending; the pending result is lost.
- Handshakes:
  - A beat is accepted when in_valid & in_ready.
  - in_ready = ~flush & (~out_valid | out_ready). Input stalls only while an unconsumed result is held.
  - A result is consumed when out_valid & out_ready.
  - out_data, out_ovf and out_count are stable while out_valid is high and out_ready is low.
- Arithmetic per accepted beat:
  - base = 0 in IDLE, acc in ACCUM.
  - raw = base + in_data, computed WIDTH+1 bits wide.
  - Overflow occurs when both operand signs are equal and the WIDTH-bit truncated sign differs.
  - With saturation enabled: positive overflow gives 2^(WIDTH-1)-1; negative overflow gives -2^(WIDTH-1).
  - With saturation disabled: the truncated WIDTH-bit sum is kept.
  - Overflow sets the sticky flag in both modes.
  - cnt increments and saturates at 2^CNT_W-1; count saturation does not set ovf.
- State machine:
  - IDLE, accepted beat with in_last = 0: go to ACCUM; acc = result, cnt = 1, sticky = this beat's overflow.
  - ACCUM, accepted beat with in_last = 0: stay in ACCUM; update acc, cnt and sticky.
  - Accepted beat with in_last = 1, from either state:
    - on the next edge, out_data = result, out_ovf = sticky | this beat's overflow, out_count = cnt+1 (saturating), out_valid = 1;
    - acc, cnt and sticky are cleared, and state goes to IDLE.
  - A single-beat group therefore returns in_data itself, and its out_ovf is always 0.
- Latency: the result is visible one cycle after the last beat is accepted. Throughput is one beat per cycle.
- out_valid control:
  - out_valid clears on consumption unless a new in_last beat is accepted in the same cycle. In that case the register reloads with the new result and out_valid stays 1.
  - Back-to-back single-beat groups therefore sustain one result per cycle when out_ready is held high.
- flush:
  - Clears acc, cnt and sticky and forces IDLE on the next edge.
  - Forces in_ready low, so no beat is accepted in a flush cycle.
  - Does not touch the output register or out_valid.
- busy = (state == ACCUM).

Test Plan:
1. WIDTH=14, sat_en=1, beats 100, 200, -50 (last) with out_ready high:
   - out_valid rises one cycle after the last beat;
   - out_data = 250, out_ovf = 0, out_count = 3.
2. Beats 8000, 500 (last):
   - with sat_en=1: out_data = 8191 (0x1FFF), out_ovf = 1;
   - with sat_en=0: out_data = 0x2134 (-7884), out_ovf = 1.
3. sat_en=1, beats -8000, -500, 300 (last):
   - intermediate acc = -8192, then the final result = -7892;
   - out_ovf = 1 (sticky), out_count = 3.
4. Backpressure: complete group {5 (last)}, hold out_ready low for 4 cycles while in_valid is high:
   - in_ready stays 0 and the outputs are stable at 5/0/1;
   - raise out_ready in the same cycle a beat 7 (last) is presented: it is accepted, and the next cycle gives out_data = 7 with out_valid still 1.
5. Flush, reset and count saturation:
   - Flush: beats 10, 20, then flush high for one cycle with in_valid high:
     - in_ready = 0 in that cycle, and busy = 0 the next cycle;
     - a following group {3 (last)} gives out_data = 3, out_count = 1.
   - Reset: assert rst mid-group with a result pending → out_valid = 0, busy = 0, all outputs 0.
   - Count saturation: with CNT_W=2, a 6-beat group of 1s gives out_count = 3, out_data = 6, out_ovf = 0.
